fpa_share_arbiter: RTL
======================

Name: fpa_share_arbiter

Overview:
Round-robin arbiter that time-shares one fpa `top` datapath (add/mult, operands number_A/number_B, result number_out) between N requesters. It registers the winning operands into the unit and tracks the in-flight tag through a LATENCY-deep pipe. It captures each result into a per-requester response buffer with a valid/ready handshake. It sits between the SIMD lane front-ends and the single shared FP unit.

Parameters:
N, 4, number of requesters (2..8)
LATENCY, 1, clock cycles from fpa_number_A/B registered to fpa_number_out valid (1..8)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous active-high reset
req_valid  in  N  requester i has an operation pending
req_ready  out  N  one-hot grant; request accepted on the edge where valid&ready
req_a  in  N*32  operand A, IEEE-754 single, slice [32i+31:32i]
req_b  in  N*32  operand B, same packing
req_op  in  N  0 = add, 1 = mult
rsp_valid  out  N  result for requester i held in buffer
rsp_ready  in  N  requester i consumes result
rsp_data  out  N*32  result for requester i
fpa_number_A  out  32  registered operand A to the shared unit
fpa_number_B  out  32  registered operand B to the shared unit
fpa_op  out  1  registered op select to the shared unit
fpa_number_out  in  32  unit result

Behaviour:
- Reset (sync, rst=1 at a rising edge) has the following effects:
  - rsp_valid=0 and busy[]=0.
  - The tag pipe is cleared.
  - rr_ptr=0.
  - fpa_number_A, fpa_number_B, fpa_op and rsp_data are set to 0.
- Mid-operation reset discards every in-flight result. No rsp_valid rises from a pre-reset issue.
- busy[i] is set on accept and cleared on the rsp handshake (rsp_valid[i]&rsp_ready[i]). Each requester has at most one outstanding op.
- eligible[i] = req_valid[i] & ~busy[i] & ~rst.
- Grant: the first eligible index searching rr_ptr, rr_ptr+1, ... mod N. req_ready is one-hot of the grant, or all-zero if nothing is eligible. It is combinational from req_valid/busy/rr_ptr. At most one accept per cycle.
- On accept of i at edge E0, all of the following update:
  - fpa_number_A/B/op load req_a/req_b/req_op slice i.
  - tag pipe stage0 = {1, i}.
  - busy[i] = 1.
  - rr_ptr = (i+1) mod N.
- With no accept, the operand registers hold their value, stage0 valid=0 and rr_ptr holds.
- Tag pipe: LATENCY+1 stages, shifted every cycle, never stalls. When the last stage is valid with id k at edge E0+LATENCY+1:
  - rsp_data[k] = fpa_number_out.
  - rsp_valid[k] = 1.
  - rsp_valid therefore first reads 1 in the cycle after E0+LATENCY+1.
- The buffer cannot overflow, because busy blocks re-issue until consumed.
- rsp_valid[k] and rsp_data[k] stay stable until rsp_ready[k]. Then rsp_valid[k] clears at that edge, along with busy[k].
- Same-cycle rsp handshake and req_valid on the same i: i is still busy that cycle, so it is not granted. It becomes eligible the next cycle.
- Back-to-back: different requesters may issue on consecutive cycles. Results return in issue order, one per cycle.
- Unit results are passed through unmodified: zero, inf, NaN and subnormal are not altered by the arbiter.

Optional Feature:
Macro FPA_SHARE_ARBITER_EXC_FLAGS_EN.
- Defined: adds output rsp_flags, N*4 bits, slice i = {nan, inf, zero, subnormal}. It is decoded from fpa_number_out when captured and registered alongside rsp_data[i].
  - nan: exp=FF, mantissa!=0.
  - inf: exp=FF, mantissa=0.
  - zero: exp=00, mantissa=0.
  - subnormal: exp=00, mantissa!=0.
  - Reset value is 0. The flags hold with rsp_data.
- Undefined: the port and logic are absent. All other behaviour is identical.

Test Plan:
- Single issue, N=4, LATENCY=1, ideal unit model:
  - Stimulus: req0 = 0x3F800000 * 0x40000000, op=1.
  - Expected: req_ready[0]=1 in the same cycle. rsp_valid[0] reads 1 three cycles after the accept edge, with rsp_data[0] = 0x40000000.
- All four requesters valid at once, rr_ptr=0:
  - Expected: grants 0,1,2,3 on consecutive cycles. Responses arrive in the same order, one per cycle.
  - With req_op=0 and operands 0x3F800000 + 0x40000000 on all four: every rsp_data = 0x40400000.
- Fairness: after granting 2, make requesters 0 and 3 both valid.
  - Expected: 3 is granted first (rr_ptr=3), then 0.
- Backpressure: hold rsp_ready[1]=0 for 10 cycles with req_valid[1] held high.
  - Expected: req_ready[1] stays 0. rsp_data[1] holds 0x40900000 (3.0*1.5). It reissues only on the cycle after the rsp handshake.
- Reset mid-flight: assert rst one cycle after accepting req2.
  - Expected: rsp_valid stays 0 for the following LATENCY+3 cycles.
  - Expected: busy clear, so req2 is granted immediately after rst deasserts, and fpa_number_A reads 0 in the cycle after the reset edge.
- With FPA_SHARE_ARBITER_EXC_FLAGS_EN and the unit returning 0x7FC00000, 0x7F800000, 0x00000000, 0x00000001:
  - Expected flags: 1000, 0100, 0010, 0001 respectively.

Source files
------------

// File: rtl/fpa_share_arbiter.sv
// fpa_share_arbiter: round-robin time-sharing of one fpa datapath among N requesters.
// Winning operands are registered into the unit. A LATENCY+1 deep tag pipe tracks
// which requester owns the result that is in flight. Results land in per-requester
// response buffers, which the requester drains through a valid/ready handshake.
// Optional: define FPA_SHARE_ARBITER_EXC_FLAGS_EN to add rsp_flags, a 4-bit
// {nan, inf, zero, subnormal} class per requester that is held with rsp_data.
module fpa_share_arbiter #(
  parameter int N       = 4,
  parameter int LATENCY = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req_valid,
  output logic [N-1:0]    req_ready,
  input  logic [N*32-1:0] req_a,
  input  logic [N*32-1:0] req_b,
  input  logic [N-1:0]    req_op,
  output logic [N-1:0]    rsp_valid,
  input  logic [N-1:0]    rsp_ready,
  output logic [N*32-1:0] rsp_data,
`ifdef FPA_SHARE_ARBITER_EXC_FLAGS_EN
  output logic [N*4-1:0]  rsp_flags,
`endif
  output logic [31:0]     fpa_number_A,
  output logic [31:0]     fpa_number_B,
  output logic            fpa_op,
  input  logic [31:0]     fpa_number_out
);

  localparam int IDW    = $clog2(N);
  localparam int STAGES = LATENCY + 1;

  logic [N-1:0]    busy_reg;
  logic [IDW-1:0]  rr_ptr_reg;
  logic [31:0]     opa_reg;
  logic [31:0]     opb_reg;
  logic            op_reg;
  logic [STAGES-1:0] tag_valid_reg;
  logic [IDW-1:0]  tag_id_reg [STAGES];
  logic [N-1:0]    rsp_valid_reg;
  logic [N*32-1:0] rsp_data_reg;

  logic [N-1:0]    eligible;
  logic [N-1:0]    grant_onehot;
  logic [IDW-1:0]  grant_idx;
  logic            grant_any;

  // A requester that is still waiting on its own result cannot issue again.
  assign eligible = req_valid & ~busy_reg & {N{~rst}};

  // Round-robin search from rr_ptr. Scanning offsets downward lets the nearest eligible index win.
  always_comb begin
    int idx;
    grant_any    = 1'b0;
    grant_idx    = '0;
    grant_onehot = '0;
    idx          = 0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = int'(rr_ptr_reg) + k;
      if (idx >= N) idx = idx - N;
      if (eligible[idx]) begin
        grant_any = 1'b1;
        grant_idx = IDW'(idx);
      end
    end
    if (grant_any) grant_onehot = N'(1) << grant_idx;
  end

  assign req_ready    = grant_onehot;
  assign fpa_number_A = opa_reg;
  assign fpa_number_B = opb_reg;
  assign fpa_op       = op_reg;
  assign rsp_valid    = rsp_valid_reg;
  assign rsp_data     = rsp_data_reg;

  // Busy marks one outstanding op per requester, from accept until its response is consumed.
  always_ff @(posedge clk) begin
    if (rst) busy_reg <= '0;
    else     busy_reg <= (busy_reg | grant_onehot) & ~(rsp_valid_reg & rsp_ready);
  end

  // The pointer moves past the winner so the next search starts with its neighbour.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_reg <= '0;
    end else if (grant_any) begin
      rr_ptr_reg <= (grant_idx == IDW'(N - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  // The operand registers feeding the shared unit load only on accept and hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      opa_reg <= '0;
      opb_reg <= '0;
      op_reg  <= 1'b0;
    end else if (grant_any) begin
      opa_reg <= req_a[32*int'(grant_idx) +: 32];
      opb_reg <= req_b[32*int'(grant_idx) +: 32];
      op_reg  <= req_op[grant_idx];
    end
  end

  // The tag pipe shifts every cycle and never stalls. Its last stage names the owner of fpa_number_out.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_valid_reg <= '0;
      for (int s = 0; s < STAGES; s++) tag_id_reg[s] <= '0;
    end else begin
      tag_valid_reg <= {tag_valid_reg[STAGES-2:0], grant_any};
      tag_id_reg[0] <= grant_idx;
      for (int s = 1; s < STAGES; s++) tag_id_reg[s] <= tag_id_reg[s-1];
    end
  end

`ifdef FPA_SHARE_ARBITER_EXC_FLAGS_EN
  logic [N*4-1:0] rsp_flags_reg;
  logic [3:0]     out_class;
  logic [7:0]     out_exp;
  logic           out_man_nz;

  assign out_exp    = fpa_number_out[30:23];
  assign out_man_nz = |fpa_number_out[22:0];
  assign out_class  = {(out_exp == 8'hFF) &  out_man_nz,
                       (out_exp == 8'hFF) & ~out_man_nz,
                       (out_exp == 8'h00) & ~out_man_nz,
                       (out_exp == 8'h00) &  out_man_nz};
  assign rsp_flags  = rsp_flags_reg;
`endif

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_rsp
      logic capture;
      assign capture = tag_valid_reg[LATENCY] && (tag_id_reg[LATENCY] == IDW'(gi));

      // Response buffer: filled from the unit when this requester's tag exits the pipe, and emptied by the handshake.
      always_ff @(posedge clk) begin
        if (rst) begin
          rsp_valid_reg[gi]          <= 1'b0;
          rsp_data_reg[32*gi +: 32]  <= '0;
        end else if (capture) begin
          rsp_valid_reg[gi]          <= 1'b1;
          rsp_data_reg[32*gi +: 32]  <= fpa_number_out;
        end else if (rsp_ready[gi]) begin
          rsp_valid_reg[gi]          <= 1'b0;
        end
      end

`ifdef FPA_SHARE_ARBITER_EXC_FLAGS_EN
      // The class flags are captured together with the data and held with it.
      always_ff @(posedge clk) begin
        if (rst)          rsp_flags_reg[4*gi +: 4] <= '0;
        else if (capture) rsp_flags_reg[4*gi +: 4] <= out_class;
      end
`endif
    end
  endgenerate

endmodule
